mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Pipeline register and writeback select between the data-memory stage and the register file of the 64-bit LEGv8 pipelined CPU. It captures the memory-stage results and selects the writeback value: loaded data or ALU result. It drives the register-file write port and supplies writeback-to-execute forwarding match signals. It also keeps a 64-bit retired-instruction counter for the testbench and performance checks.

## Interface
Parameters: none (all widths fixed by the ISA).

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold WB register contents this cycle
- flush  in  1  replace incoming instruction with a bubble this cycle
- valid_mem  in  1  memory-stage slot holds a real instruction
- RegWrite_mem  in  1  instruction writes a register
- MemtoReg_in  in  1  1 = write back dm_read_data, 0 = write back dm_address
- Rd_mem  in  5  destination register number
- dm_address  in  64  ALU result forwarded from the memory stage
- dm_read_data  in  64  data memory read data
- ex_Rn, ex_Rm  in  5 each  source registers of the instruction currently in execute
- valid_wb  out  1  WB slot holds a real instruction
- RegWrite_wb  out  1  effective register-file write enable
- Rd_wb  out  5  register-file write address
- wb_data  out  64  register-file write data
- fwd_Rn_wb, fwd_Rm_wb  out  1 each  WB result must be forwarded to execute operand Rn / Rm
- instret  out  64  count of instructions captured into WB

## Operation
- Registered fields are v, rw, m2r, rd, addr and rdata.
- Update priority at each rising edge is reset > flush > stall > load.
- **Reset:** v=0, rw=0, m2r=0, rd=31, addr=0, rdata=0, instret=0.
- **Flush:** the register takes a bubble (v=0, rw=0, m2r=0, rd=31, addr=0, rdata=0). instret is unchanged.
- **Stall (no flush):** all fields and instret hold.
- **Load:** fields take their *_mem inputs. instret increments by 1 when valid_mem=1. instret wraps from 2^64-1 to 0.
- **Combinational outputs:**
  - valid_wb = v; Rd_wb = rd.
  - wb_data = m2r ? rdata : addr.
  - RegWrite_wb = v & rw & (rd != 31). X31 is XZR and is never written.
  - fwd_Rn_wb = RegWrite_wb & (rd == ex_Rn); fwd_Rm_wb = RegWrite_wb & (rd == ex_Rm).
- Because register 31 can never drive RegWrite_wb, no forward occurs for XZR.
- A bubble never writes or forwards, regardless of stale field values.

## Timing
- Latency is 1 cycle: the memory-stage values present before edge N appear on the outputs after edge N.
- wb_data, RegWrite_wb and the fwd_* signals are combinational from the registered state and ex_Rn/ex_Rm.
- No handshake is used. stall and flush are level inputs sampled at each rising edge.
- Simultaneous flush and stall: flush wins and a bubble is loaded.
- Reset mid-stall or mid-flush: reset wins. Outputs show reset values after that edge. The counter restarts at 0.
- stall held for k cycles: outputs are constant for k cycles. instret does not double-count.
- dm_read_data is sampled at the same edge as the other inputs. The upstream memory read is therefore complete within the memory-stage cycle.

## Test plan
- **Reset:** reset=1 for 2 edges with random inputs -> valid_wb=0, RegWrite_wb=0, Rd_wb=31, wb_data=0, instret=0.
- **ALU then load writeback:**
  - Load valid_mem=1, RegWrite_mem=1, MemtoReg_in=0, Rd_mem=5, dm_address=0x1234 -> next cycle Rd_wb=5, wb_data=0x1234, RegWrite_wb=1, instret=1.
  - Then MemtoReg_in=1, dm_read_data=0xDEADBEEF, Rd_mem=6 -> wb_data=0xDEADBEEF, instret=2.
- **XZR:** RegWrite_mem=1, Rd_mem=31, valid_mem=1 -> RegWrite_wb=0. With ex_Rn=31, fwd_Rn_wb=0. instret still increments.
- **Stall/flush:**
  - stall=1 for 3 cycles after loading Rd=7 while inputs change -> outputs frozen at Rd=7, instret unchanged.
  - stall=1 and flush=1 together -> bubble: valid_wb=0, RegWrite_wb=0.
- **Forwarding:** WB holds Rd=9 with RegWrite=1.
  - ex_Rn=9, ex_Rm=3 -> fwd_Rn_wb=1, fwd_Rm_wb=0.
  - ex_Rn=9, ex_Rm=9 -> both 1.
  - Same case with valid=0 -> both 0.
- **Counter wrap and reset:** force instret to 2^64-1 through 2^64-1 valid loads, or load it via a hierarchical poke, then load one valid instruction -> instret=0. Asserting reset during a stalled valid instruction -> next cycle all outputs are at reset values.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the 64-bit LEGv8 pipeline: captures memory-stage
// results, selects writeback data, drives the register-file write port and WB forwarding.
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_mem,
  input  logic        RegWrite_mem,
  input  logic        MemtoReg_in,
  input  logic [4:0]  Rd_mem,
  input  logic [63:0] dm_address,
  input  logic [63:0] dm_read_data,
  input  logic [4:0]  ex_Rn,
  input  logic [4:0]  ex_Rm,
  output logic        valid_wb,
  output logic        RegWrite_wb,
  output logic [4:0]  Rd_wb,
  output logic [63:0] wb_data,
  output logic        fwd_Rn_wb,
  output logic        fwd_Rm_wb,
  output logic [63:0] instret
);

  localparam logic [4:0] XZR = 5'd31;

  logic        v_r;
  logic        rw_r;
  logic        m2r_r;
  logic [4:0]  rd_r;
  logic [63:0] addr_r;
  logic [63:0] rdata_r;
  logic [63:0] instret_r;

  logic        regwrite_s;
  logic [63:0] wb_data_s;
  logic        fwd_rn_s;
  logic        fwd_rm_s;

  // Pipeline register update: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_r       <= 1'b0;
      rw_r      <= 1'b0;
      m2r_r     <= 1'b0;
      rd_r      <= XZR;
      addr_r    <= 64'd0;
      rdata_r   <= 64'd0;
      instret_r <= 64'd0;
    end else if (flush) begin
      // Bubble targets XZR so stale fields can never write or forward.
      v_r       <= 1'b0;
      rw_r      <= 1'b0;
      m2r_r     <= 1'b0;
      rd_r      <= XZR;
      addr_r    <= 64'd0;
      rdata_r   <= 64'd0;
      instret_r <= instret_r;
    end else if (stall) begin
      v_r       <= v_r;
      rw_r      <= rw_r;
      m2r_r     <= m2r_r;
      rd_r      <= rd_r;
      addr_r    <= addr_r;
      rdata_r   <= rdata_r;
      instret_r <= instret_r;
    end else begin
      v_r       <= valid_mem;
      rw_r      <= RegWrite_mem;
      m2r_r     <= MemtoReg_in;
      rd_r      <= Rd_mem;
      addr_r    <= dm_address;
      rdata_r   <= dm_read_data;
      instret_r <= instret_r + {63'd0, valid_mem};
    end
  end

  // Writeback select, XZR-suppressed write enable and forwarding match.
  always_comb begin
    wb_data_s  = 64'd0;
    regwrite_s = 1'b0;
    fwd_rn_s   = 1'b0;
    fwd_rm_s   = 1'b0;
    if (m2r_r) begin
      wb_data_s = rdata_r;
    end else begin
      wb_data_s = addr_r;
    end
    regwrite_s = v_r & rw_r & (rd_r != XZR);
    fwd_rn_s   = regwrite_s & (rd_r == ex_Rn);
    fwd_rm_s   = regwrite_s & (rd_r == ex_Rm);
  end

  assign valid_wb    = v_r;
  assign Rd_wb       = rd_r;
  assign wb_data     = wb_data_s;
  assign RegWrite_wb = regwrite_s;
  assign fwd_Rn_wb   = fwd_rn_s;
  assign fwd_Rm_wb   = fwd_rm_s;
  assign instret     = instret_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage, plus hand sequences for
// reset, counter wrap and reset during a stall.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        valid_mem;
  logic        RegWrite_mem;
  logic        MemtoReg_in;
  logic [4:0]  Rd_mem;
  logic [63:0] dm_address;
  logic [63:0] dm_read_data;
  logic [4:0]  ex_Rn;
  logic [4:0]  ex_Rm;
  logic        valid_wb;
  logic        RegWrite_wb;
  logic [4:0]  Rd_wb;
  logic [63:0] wb_data;
  logic        fwd_Rn_wb;
  logic        fwd_Rm_wb;
  logic [63:0] instret;

  int n_tests;
  int n_fail;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem), .MemtoReg_in(MemtoReg_in),
    .Rd_mem(Rd_mem), .dm_address(dm_address), .dm_read_data(dm_read_data),
    .ex_Rn(ex_Rn), .ex_Rm(ex_Rm),
    .valid_wb(valid_wb), .RegWrite_wb(RegWrite_wb), .Rd_wb(Rd_wb), .wb_data(wb_data),
    .fwd_Rn_wb(fwd_Rn_wb), .fwd_Rm_wb(fwd_Rm_wb), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [4:0]  ex_rn;
    logic [4:0]  ex_rm;
    logic        e_v;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        e_fn;
    logic        e_fm;
    logic [63:0] e_instret;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_v, input logic e_rw,
                           input logic [4:0] e_rd, input logic [63:0] e_data,
                           input logic e_fn, input logic e_fm, input logic [63:0] e_ir);
    check({tag, ".valid_wb"},    {63'd0, valid_wb},    {63'd0, e_v});
    check({tag, ".RegWrite_wb"}, {63'd0, RegWrite_wb}, {63'd0, e_rw});
    check({tag, ".Rd_wb"},       {59'd0, Rd_wb},       {59'd0, e_rd});
    check({tag, ".wb_data"},     wb_data,              e_data);
    check({tag, ".fwd_Rn_wb"},   {63'd0, fwd_Rn_wb},   {63'd0, e_fn});
    check({tag, ".fwd_Rm_wb"},   {63'd0, fwd_Rm_wb},   {63'd0, e_fm});
    check({tag, ".instret"},     instret,              e_ir);
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic rw,
                       input logic m2r, input logic [4:0] rd, input logic [63:0] addr,
                       input logic [63:0] rdata, input logic [4:0] rn, input logic [4:0] rm);
    stall = s; flush = f; valid_mem = v; RegWrite_mem = rw; MemtoReg_in = m2r;
    Rd_mem = rd; dm_address = addr; dm_read_data = rdata; ex_Rn = rn; ex_Rm = rm;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //            st    fl    v     rw    m2r   rd     addr           rdata               rn     rm     | v    rw    rd     data                fn    fm    instret
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  64'h1234, 64'h55,         5'd0,  5'd0,  1'b1, 1'b1, 5'd5,  64'h1234,       1'b0, 1'b0, 64'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6,  64'h99,   64'hDEADBEEF,   5'd6,  5'd1,  1'b1, 1'b1, 5'd6,  64'hDEADBEEF,   1'b1, 1'b0, 64'd2};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd31, 64'h77,   64'h0,          5'd31, 5'd31, 1'b1, 1'b0, 5'd31, 64'h77,         1'b0, 1'b0, 64'd3};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7,  64'h700,  64'h1,          5'd7,  5'd0,  1'b1, 1'b1, 5'd7,  64'h700,        1'b1, 1'b0, 64'd4};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  64'h800,  64'h888,        5'd7,  5'd8,  1'b1, 1'b1, 5'd7,  64'h700,        1'b1, 1'b0, 64'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  64'h900,  64'h999,        5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  64'h700,        1'b1, 1'b1, 64'd4};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2,  64'hA,    64'hB,          5'd0,  5'd7,  1'b1, 1'b1, 5'd7,  64'h700,        1'b0, 1'b1, 64'd4};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4,  64'h444,  64'h4444,       5'd31, 5'd4,  1'b0, 1'b0, 5'd31, 64'h0,          1'b0, 1'b0, 64'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9,  64'h900,  64'h1,          5'd9,  5'd3,  1'b1, 1'b1, 5'd9,  64'h900,        1'b1, 1'b0, 64'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  64'h901,  64'h9999,       5'd9,  5'd9,  1'b1, 1'b1, 5'd9,  64'h9999,       1'b1, 1'b1, 64'd6};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  64'hA00,  64'h1,          5'd9,  5'd9,  1'b0, 1'b0, 5'd9,  64'hA00,        1'b0, 1'b0, 64'd6};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  64'hB00,  64'h1,          5'd9,  5'd9,  1'b1, 1'b0, 5'd9,  64'hB00,        1'b0, 1'b0, 64'd7};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 64'hC00,  64'hCCC,        5'd31, 5'd12, 1'b0, 1'b0, 5'd31, 64'h0,          1'b0, 1'b0, 64'd7};

    // Reset for two edges with random inputs.
    reset = 1'b1;
    drive($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 1'b1, $urandom_range(0, 1),
          5'($urandom_range(0, 30)), {$urandom, $urandom}, {$urandom, $urandom},
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    repeat (2) @(posedge clk);
    #1;
    ex_Rn = 5'd31; ex_Rm = 5'd31;
    #1;
    check_all("reset", 1'b0, 1'b0, 5'd31, 64'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rw, vecs[i].m2r,
            vecs[i].rd, vecs[i].addr, vecs[i].rdata, vecs[i].ex_rn, vecs[i].ex_rm);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_rw, vecs[i].e_rd,
                vecs[i].e_data, vecs[i].e_fn, vecs[i].e_fm, vecs[i].e_instret);
      @(negedge clk);
    end

    // Counter wrap: preload all-ones, then one valid load.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
    force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_r;
    #1;
    check("wrap.preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 64'h33, 64'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    check("wrap.instret", instret, 64'd0);
    @(negedge clk);

    // Reset asserted while a valid instruction is stalled in WB.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10, 64'hAAAA, 64'd0, 5'd10, 5'd10);
    @(posedge clk);
    #1;
    check_all("pre_rst", 1'b1, 1'b1, 5'd10, 64'hAAAA, 1'b1, 1'b1, 64'd1);
    @(negedge clk);
    stall = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_stall", 1'b0, 1'b0, 5'd31, 64'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
